// File: rtl/opresp_pkg.sv
// Shared types for the operand responder: opcode encoding and widths.
// The per-instance result bundle lives in operand_responder (it depends on N).
package opresp_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_e;

endpackage

// File: rtl/opresp_fifo.sv
// Synchronous result FIFO for the operand responder.
// Push is honoured when not full, or when full with a simultaneous pop.
module opresp_fifo
  import opresp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/operand_responder.sv
// Responder for the a/b -> c operand interface: compute stage plus result FIFO.
// Define OPERAND_RESPONDER_SAT_EN to saturate ADD/SUB instead of wrapping.
module operand_responder
  import opresp_pkg::*;
#(
  parameter int N     = 10,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [N-1:0]    req_a,
  input  logic [N-1:0]    req_b,
  input  logic [OP_W-1:0] req_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [N-1:0]    rsp_c,
  output logic            rsp_ovf,
  output logic [15:0]     txn_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;

`ifdef OPERAND_RESPONDER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0] c;
    logic         ovf;
  } rsp_t;

  logic        stage_vld_q, stage_vld_d;
  rsp_t        stage_rsp_q, stage_rsp_d;
  logic [15:0] txn_count_q, txn_count_d;

  rsp_t        res;
  rsp_t        fifo_dout;
  logic [N:0]  wide_add, wide_sub;
  logic [AW:0] fifo_count;
  logic [CW-1:0] occ;
  logic        fifo_empty, fifo_full;
  logic        accept, pop;

  always_comb begin
    wide_add = {1'b0, req_a} + {1'b0, req_b};
    wide_sub = {1'b0, req_a} - {1'b0, req_b};
    res      = '0;
    unique case (op_e'(req_op))
      OP_ADD: begin
        res.ovf = wide_add[N];
        res.c   = (SAT_EN && wide_add[N]) ? '1 : wide_add[N-1:0];
      end
      OP_SUB: begin
        res.ovf = wide_sub[N];
        res.c   = (SAT_EN && wide_sub[N]) ? '0 : wide_sub[N-1:0];
      end
      OP_AND: res.c = req_a & req_b;
      OP_XOR: res.c = req_a ^ req_b;
    endcase
  end

  // Counting the stage slot reserves FIFO room, so a stage entry never waits.
  assign occ       = CW'(fifo_count) + CW'(stage_vld_q);
  assign req_ready = !rst && !fifo_full && (occ < CW'(DEPTH));
  assign accept    = req_valid && req_ready;

  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_c     = rsp_valid ? fifo_dout.c : '0;
  assign rsp_ovf   = rsp_valid ? fifo_dout.ovf : 1'b0;
  assign txn_count = txn_count_q;

  always_comb begin
    stage_vld_d = accept;
    stage_rsp_d = accept ? res : stage_rsp_q;
    txn_count_d = txn_count_q + 16'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_vld_q <= 1'b0;
      stage_rsp_q <= '0;
      txn_count_q <= '0;
    end else begin
      stage_vld_q <= stage_vld_d;
      stage_rsp_q <= stage_rsp_d;
      txn_count_q <= txn_count_d;
    end
  end

  opresp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(rsp_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (stage_vld_q),
    .pop   (pop),
    .din   (stage_rsp_q),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_operand_responder.sv
// Directed self-checking bench for operand_responder (N=10, DEPTH=4).
// Expected values follow OPERAND_RESPONDER_SAT_EN when it is defined.
module tb_operand_responder;
  import opresp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_a;
  logic [9:0]  req_b;
  logic [1:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [9:0]  rsp_c;
  logic        rsp_ovf;
  logic [15:0] txn_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_responder #(
    .N     (10),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .rsp_ovf   (rsp_ovf),
    .txn_count (txn_count)
  );

  // Issue one request with rsp_ready=1, wait (bounded) for its result, pop it.
  task automatic send_one(input logic [9:0] a, input logic [9:0] b,
                          input logic [1:0] op, output logic got,
                          output int lat, output logic [9:0] c,
                          output logic ovf);
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    got = rsp_valid;
    c   = rsp_c;
    ovf = rsp_ovf;
    @(posedge clk);
  endtask

  task automatic test_reset;
    int seen;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = 2'd0;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready got %b want 0", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", rsp_valid);
    end
    checks++;
    if (rsp_c !== 10'd0 || rsp_ovf !== 1'b0) begin
      errors++;
      $display("FAIL rst_c got %0d/%b want 0/0", rsp_c, rsp_ovf);
    end
    checks++;
    if (txn_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_txn got %0d want 0", txn_count);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready got %b want 1", req_ready);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL idle_valid got %0d high cycles want 0", seen);
    end
  endtask

  task automatic test_add_basic;
    logic got, ovf;
    int lat;
    logic [9:0] c;
    send_one(10'd3, 10'd4, 2'd0, got, lat, c, ovf);
    checks++;
    if (got !== 1'b1 || lat != 2) begin
      errors++;
      $display("FAIL add_lat got valid=%b lat=%0d want 1/2", got, lat);
    end
    checks++;
    if (c !== 10'd7 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL add_c got %0d/%b want 7/0", c, ovf);
    end
    @(negedge clk);
    checks++;
    if (txn_count !== 16'd1) begin
      errors++;
      $display("FAIL add_txn got %0d want 1", txn_count);
    end
  endtask

  task automatic test_overflow;
    logic got, ovf;
    int lat;
    logic [9:0] c;
    logic [9:0] exp_add, exp_sub;
`ifdef OPERAND_RESPONDER_SAT_EN
    exp_add = 10'd1023;
    exp_sub = 10'd0;
`else
    exp_add = 10'd0;
    exp_sub = 10'd1021;
`endif
    send_one(10'd1023, 10'd1, 2'd0, got, lat, c, ovf);
    checks++;
    if (got !== 1'b1 || c !== exp_add || ovf !== 1'b1) begin
      errors++;
      $display("FAIL add_ovf got %b/%0d/%b want 1/%0d/1", got, c, ovf, exp_add);
    end
    send_one(10'd2, 10'd5, 2'd1, got, lat, c, ovf);
    checks++;
    if (got !== 1'b1 || c !== exp_sub || ovf !== 1'b1) begin
      errors++;
      $display("FAIL sub_brw got %b/%0d/%b want 1/%0d/1", got, c, ovf, exp_sub);
    end
    @(negedge clk);
    checks++;
    if (txn_count !== 16'd3) begin
      errors++;
      $display("FAIL ovf_txn got %0d want 3", txn_count);
    end
  endtask

  task automatic test_stall_fill;
    logic [9:0] exp_c [4];
    int acc, idx;
    exp_c[0] = 10'd11;
    exp_c[1] = 10'd12;
    exp_c[2] = 10'd13;
    exp_c[3] = 10'd14;
    acc = 0;
    idx = 0;
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      req_valid = 1'b1;
      req_a     = 10'(idx + 1);
      req_b     = 10'd10;
      req_op    = 2'd0;
      if (req_ready) begin
        acc++;
        idx++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    checks++;
    if (acc != 4) begin
      errors++;
      $display("FAIL fill_acc got %0d want 4", acc);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_ready got %b want 0", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_c !== 10'd11 || rsp_ovf !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold got %b/%0d/%b want 1/11/0",
               rsp_valid, rsp_c, rsp_ovf);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_c !== exp_c[i]) begin
        errors++;
        $display("FAIL drain_%0d got %b/%0d want 1/%0d",
                 i, rsp_valid, rsp_c, exp_c[i]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_end got ready=%b valid=%b want 1/0",
               req_ready, rsp_valid);
    end
    checks++;
    if (txn_count !== 16'd7) begin
      errors++;
      $display("FAIL drain_txn got %0d want 7", txn_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] va [8];
    logic [9:0] vb [8];
    logic [1:0] vo [8];
    logic [9:0] ec [8];
    logic       eo [8];
    va[0] = 10'd10;   vb[0] = 10'd20;  vo[0] = 2'd0; ec[0] = 10'd30;   eo[0] = 1'b0;
    va[1] = 10'd100;  vb[1] = 10'd40;  vo[1] = 2'd1; ec[1] = 10'd60;   eo[1] = 1'b0;
    va[2] = 10'h3F0;  vb[2] = 10'h0FF; vo[2] = 2'd2; ec[2] = 10'h0F0;  eo[2] = 1'b0;
    va[3] = 10'h2AA;  vb[3] = 10'h155; vo[3] = 2'd3; ec[3] = 10'h3FF;  eo[3] = 1'b0;
    va[4] = 10'd500;  vb[4] = 10'd600; vo[4] = 2'd0; ec[4] = 10'd76;   eo[4] = 1'b1;
    va[5] = 10'd7;    vb[5] = 10'd7;   vo[5] = 2'd1; ec[5] = 10'd0;    eo[5] = 1'b0;
    va[6] = 10'd5;    vb[6] = 10'd3;   vo[6] = 2'd3; ec[6] = 10'd6;    eo[6] = 1'b0;
    va[7] = 10'd0;    vb[7] = 10'd1;   vo[7] = 2'd1; ec[7] = 10'd1023; eo[7] = 1'b1;
`ifdef OPERAND_RESPONDER_SAT_EN
    ec[4] = 10'd1023;
    ec[7] = 10'd0;
`endif
    @(negedge clk);
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (k < 2) begin
        if (rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_early_%0d got valid=%b want 0", k, rsp_valid);
        end
      end else if (rsp_valid !== 1'b1 || rsp_c !== ec[k-2] ||
                   rsp_ovf !== eo[k-2]) begin
        errors++;
        $display("FAIL b2b_%0d got %b/%0d/%b want 1/%0d/%b",
                 k - 2, rsp_valid, rsp_c, rsp_ovf, ec[k-2], eo[k-2]);
      end
      if (k < 8) begin
        req_valid = 1'b1;
        req_a     = va[k];
        req_b     = vb[k];
        req_op    = vo[k];
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got valid=%b want 0", rsp_valid);
    end
    checks++;
    if (txn_count !== 16'd15) begin
      errors++;
      $display("FAIL b2b_txn got %0d want 15", txn_count);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1;
      req_a     = 10'(k);
      req_b     = 10'd1;
      req_op    = 2'd0;
      @(posedge clk);
      @(negedge clk);
    end
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b0) seen++;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_rst_valid got %0d high cycles want 0", seen);
    end
    checks++;
    if (txn_count !== 16'd0 || rsp_c !== 10'd0) begin
      errors++;
      $display("FAIL mid_rst_state got txn=%0d c=%0d want 0/0",
               txn_count, rsp_c);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst_ready got %b want 1", req_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_basic();
    test_overflow();
    test_stall_fill();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
